// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic/compare ops, with an iterative
// 1-bit-per-cycle shifter for SLL/SRL/SRA; results leave over a valid/ready handshake.
module alu_exec_unit #(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_work;
  logic            r_zero;
  logic            r_illegal;
  logic [SHW-1:0]  r_count;
  logic [3:0]      r_op;

  logic                   w_in_ready;
  logic                   w_accept;
  logic [SHW-1:0]         w_shamt;
  logic                   w_is_shift;
  logic                   w_start_shift;
  logic                   w_legal;
  logic [XLEN-1:0]        w_calc;
  logic [XLEN-1:0]        w_shift_nxt;
  logic                   w_last_shift;
  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic                   w_lt_s;
  logic                   w_lt_u;

  // One-bit step of the iterative shifter; SRA replicates the current top bit.
  function automatic logic [XLEN-1:0] f_shift1(input logic [XLEN-1:0] w,
                                                input logic [3:0]      op);
    logic [XLEN-1:0] v;
    case (op)
      OP_SLL:  v = {w[XLEN-2:0], 1'b0};
      OP_SRA:  v = {w[XLEN-1], w[XLEN-1:1]};
      default: v = {1'b0, w[XLEN-1:1]};
    endcase
    return v;
  endfunction

  assign w_a_s  = op_a;
  assign w_b_s  = op_b;
  assign w_lt_s = (w_a_s < w_b_s);
  assign w_lt_u = (op_a < op_b);

  assign w_shamt       = op_b[SHW-1:0];
  assign w_is_shift    = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign w_start_shift = w_accept && w_is_shift && (w_shamt != '0);
  assign w_shift_nxt   = f_shift1(r_work, r_op);
  assign w_last_shift  = (r_count == SHW'(1));

  // Single-cycle datapath; a shift reaching here has a zero amount, so it passes op_a.
  always_comb begin
    w_calc  = '0;
    w_legal = 1'b1;
    case (alu_ctrl)
      OP_AND:  w_calc = op_a & op_b;
      OP_OR:   w_calc = op_a | op_b;
      OP_ADD:  w_calc = op_a + op_b;
      OP_XOR:  w_calc = op_a ^ op_b;
      OP_SUB:  w_calc = op_a - op_b;
      OP_SLTU: w_calc = {{(XLEN-1){1'b0}}, w_lt_u};
      OP_SLT:  w_calc = {{(XLEN-1){1'b0}}, w_lt_s};
      OP_SLL, OP_SRL, OP_SRA: w_calc = op_a;
      default: begin
        w_calc  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready = 1'b1;
      S_DONE:  w_in_ready = out_ready;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid && w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_start_shift ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (w_last_shift) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_accept)       w_state_nxt = w_start_shift ? S_SHIFT : S_DONE;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Result / shifter registers: loaded on accept, stepped while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_work    <= '0;
      r_count   <= '0;
      r_op      <= '0;
    end else if (w_accept) begin
      if (w_start_shift) begin
        r_work  <= op_a;
        r_count <= w_shamt;
        r_op    <= alu_ctrl;
      end else begin
        r_result  <= w_calc;
        r_zero    <= (w_calc == '0);
        r_illegal <= !w_legal;
      end
    end else if (r_state == S_SHIFT) begin
      r_work  <= w_shift_nxt;
      r_count <= r_count - SHW'(1);
      if (w_last_shift) begin
        r_result  <= w_shift_nxt;
        r_zero    <= (w_shift_nxt == '0);
        r_illegal <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (XLEN=64) with hand-computed expectations.
module tb_alu_exec_unit;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic            busy;

  int n_vec;
  int n_miss;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // Present an op, wait for the accepting edge, then scramble inputs so the
  // in-flight op must rely on its latched copy. Returns #1 after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    int guard;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("accept_timeout", 64'(guard), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    op_a     = {$urandom, $urandom};
    op_b     = {$urandom, $urandom};
  endtask

  // Extra edges after the accept edge until out_valid, noting whether busy was seen.
  task automatic wait_out(output int lat, output bit saw_busy);
    lat      = 0;
    saw_busy = 1'b0;
    while (!out_valid && lat < 200) begin
      if (busy) saw_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res,
                        input logic exp_zero, input logic exp_ill, input int exp_lat);
    int lat;
    bit sb;
    issue(c, a, b);
    wait_out(lat, sb);
    chk({tag, "_lat"},    64'(lat),     64'(exp_lat));
    chk({tag, "_res"},    result,       exp_res);
    chk({tag, "_zero"},   64'(zero),    64'(exp_zero));
    chk({tag, "_ill"},    64'(illegal), 64'(exp_ill));
    chk({tag, "_busy"},   64'(sb),      64'(exp_lat > 0));
    @(posedge clk); #1;
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = 4'd0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_result",    result,         64'd0);
    chk("rst_zero",      64'(zero),      64'd0);
    chk("rst_illegal",   64'(illegal),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    run_op("add",  4'b0010, 64'd5,  64'd7,  64'd12, 1'b0, 1'b0, 0);
    run_op("sub",  4'b0110, 64'd7,  64'd7,  64'd0,  1'b1, 1'b0, 0);
    run_op("slt",  4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0, 0);
    run_op("sltu", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 0);
    run_op("and",  4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 0);
    run_op("or",   4'b0001, 64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0, 1'b0, 0);
    run_op("addw", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 0);
    run_op("sra4", 4'b1001, 64'h8000_0000_0000_0000, 64'd4,
           64'hF800_0000_0000_0000, 1'b0, 1'b0, 4);
    run_op("sll3", 4'b0100, 64'h1234, 64'h43, 64'h91A0, 1'b0, 1'b0, 3);
    run_op("srl0", 4'b0101, 64'hDEAD, 64'h40, 64'hDEAD, 1'b0, 1'b0, 0);
    run_op("srl63", 4'b0101, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1'b0, 63);
    run_op("sra1", 4'b1001, 64'h4000_0000_0000_0001, 64'd1,
           64'h2000_0000_0000_0000, 1'b0, 1'b0, 1);
    run_op("ill",  4'b1111, 64'h55, 64'h66, 64'd0, 1'b1, 1'b1, 0);
    run_op("and_after_ill", 4'b0000, 64'hFF, 64'h0F, 64'h0F, 1'b0, 1'b0, 0);

    // Back-to-back ADDs, one accepted and one delivered per cycle.
    alu_ctrl = 4'b0010;
    op_b     = 64'd10;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op_a = 64'(i);
      chk($sformatf("b2b_in_ready_%0d", i), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("b2b_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("b2b_res_%0d", i),   result,         64'(i + 10));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", 64'(out_valid), 64'd0);

    // Backpressure on a completed XOR while a new op waits upstream.
    out_ready = 1'b0;
    issue(4'b0011, 64'hAAAA, 64'h5555);
    alu_ctrl = 4'b0010;
    op_a     = 64'd1;
    op_b     = 64'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i),    64'(out_valid), 64'd1);
      chk($sformatf("bp_res_%0d", i),      result,         64'hFFFF);
      chk($sformatf("bp_zero_%0d", i),     64'(zero),      64'd0);
      chk($sformatf("bp_in_ready_%0d", i), 64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_res",   result,         64'd2);
    @(posedge clk); #1;
    chk("bp_idle", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a long shift.
    issue(4'b0100, 64'd1, 64'd40);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy",      64'(busy),      64'd0);
    chk("arst_result",    result,         64'd0);
    chk("arst_zero",      64'(zero),      64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_still_idle", 64'(out_valid), 64'd0);
    run_op("post_rst_add", 4'b0010, 64'd100, 64'd23, 64'd123, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU operation code from the ALU control decoder, plus two operands.
- Produces a registered result, a zero flag and an illegal-op flag over a valid/ready handshake.
- Single-cycle ops finish with 1-cycle latency. Shifts use an iterative 1-bit-per-cycle shifter, so latency depends on the shift amount.
- Sits between operand selection (register file / immediate mux) and the memory/writeback stage; branch logic reads `zero` and `result`.

Parameters:
- XLEN, 64, operand/result width (power of two, >= 8)
- SHW, $clog2(XLEN), shift-amount width taken from op_b[SHW-1:0]

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept an operation this cycle
- alu_ctrl  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLTU, 1000 SLT, 1001 SRA
- op_a  input  XLEN  first operand
- op_b  input  XLEN  second operand / shift amount
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  XLEN  operation result
- zero  output  1  result == 0
- illegal  output  1  alu_ctrl was not one of the 10 defined codes
- busy  output  1  iterative shift in progress

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, illegal=0, busy=0. Internal shift counter and work register = 0.
- Reset asserted mid-shift or while holding a result aborts the operation immediately. No output survives reset.
- FSM states and transitions:
  - IDLE: in_ready=1. Accept when in_valid.
  - SHIFT: in_ready=0, busy=1.
  - DONE: out_valid=1, in_ready=out_ready.
- Accept = in_valid && in_ready. On accept, latch alu_ctrl, op_a, op_b.
- Non-shift op, or shift with shamt==0, or illegal code: compute combinationally, register result and flags, go to DONE. Latency 1 cycle: out_valid rises on the edge after accept.
- Shift op with shamt!=0:
  - Load work=op_a and count=shamt, go to SHIFT.
  - Each cycle: work shifts by 1 (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill from work[XLEN-1]); count decrements.
  - When count reaches 1, the final shifted value is registered and the FSM enters DONE.
  - Total latency from accept to out_valid = shamt cycles, with shamt in 1..XLEN-1.
  - op_b bits above SHW-1 are ignored.
- Arithmetic:
  - ADD/SUB are modulo 2^XLEN; no carry/overflow output.
  - SLT is a signed compare; SLTU is unsigned. Both give result = {XLEN-1 zeros, lt}.
  - zero = (result == 0), registered alongside result.
- Illegal code: result=0, zero=1, illegal=1, latency 1. Not an error stall; the transfer completes normally.
- DONE holding rules:
  - result, zero and illegal stay stable while out_valid && !out_ready.
  - Transfer occurs on out_valid && out_ready.
- Simultaneous transfer and accept in DONE (out_ready && in_valid):
  - The old result is consumed and the new op accepted in the same cycle.
  - Next state is DONE (1-cycle op) or SHIFT. Sustains 1 op/cycle for non-shift ops.
- DONE with out_ready && !in_valid: go to IDLE, out_valid=0 next cycle.
- in_valid while busy is ignored (in_ready=0). The upstream stage must hold its inputs until accepted.
- alu_ctrl/op_a/op_b changes after accept have no effect on the operation in flight.

Test Plan:
- Reset: rst_n=0 asynchronously mid-SHIFT with shamt=40 -> out_valid, busy, result, zero drop to 0 without a clock edge; after release, in_ready=1.
- ADD/SUB/SLT/SLTU with out_ready=1:
  - op_a=5, op_b=7, ADD -> result=12, zero=0 one cycle after accept.
  - SUB 7-7 -> result=0, zero=1.
  - SLT op_a=-1, op_b=1 -> 1; SLTU same operands -> 0.
- Back-to-back: 8 consecutive ADDs with in_valid=out_ready=1 -> 8 results on 8 consecutive cycles, in_ready never drops.
- Shifts:
  - SRA op_a=0x8000_0000_0000_0000, op_b=4 -> 0xF800_0000_0000_0000 after 4 cycles, busy=1 in between.
  - SLL op_b=0x43 (shamt=3) -> op_a<<3 in 3 cycles.
  - SRL shamt=0 -> op_a in 1 cycle, busy never asserted.
- Backpressure: out_ready=0 for 5 cycles after an XOR completes -> result/zero stable, in_ready=0, new in_valid not accepted; out_ready=1 -> transfer, then next op accepted.
- Illegal: alu_ctrl=4'b1111 -> illegal=1, result=0, zero=1, latency 1; the next legal AND clears illegal.
